// File: rtl/bnn_param_loader.sv
// -----------------------------------------------------------------------------
// bnn_param_loader
//   Streams host parameter bytes LSB-first into the serial parameter chain of
//   the tiny_bnn neuron array, one bit per cycle. After the load it can rotate
//   the chain once through itself and compare a CRC-8 of the rotated stream
//   against the CRC of the loaded stream to confirm the load.
//
// Ports
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   start       in   one-cycle pulse, begins a load when idle
//   data_in     in   [7:0] parameter byte, bit 0 shifted first
//   data_valid  in   data_in valid
//   data_ready  out  byte accepted this cycle when data_valid is also high
//   chain_tail  in   serial output of the last neuron in the chain
//   setup       out  chain shift enable / array setup mode
//   param_in    out  serial bit into the first neuron
//   busy        out  sequence in progress (LOAD / VERIFY)
//   done        out  one-cycle pulse at end of sequence
//   error       out  verify mismatch, sticky until the next accepted start
// -----------------------------------------------------------------------------
module bnn_param_loader #(
  parameter int N_NEURONS       = 8,
  parameter int BITS_PER_NEURON = 11,
  parameter int TOTAL_BITS      = N_NEURONS * BITS_PER_NEURON,
  parameter bit VERIFY_EN       = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  input  logic       chain_tail,
  output logic       setup,
  output logic       param_in,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int            CW      = $clog2(TOTAL_BITS + 1);
  localparam logic [CW-1:0] C_TOTAL = CW'(TOTAL_BITS);
  localparam logic [CW-1:0] C_LAST  = CW'(TOTAL_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_VERIFY, S_FINISH} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_buf;
  logic [3:0]    r_occ;
  logic [CW-1:0] r_bit_cnt;
  logic [7:0]    r_crc;      // CRC of the loaded stream; frozen after LOAD as reference
  logic [7:0]    r_crc_chk;  // CRC of the stream seen at the chain tail during VERIFY
  logic          r_error;

  logic          w_shift;
  logic          w_last_bit;
  logic [CW-1:0] w_unacc;
  logic [CW-1:0] w_rem_after;
  logic          w_ready;
  logic          w_accept;
  logic [3:0]    w_occ_new;
  logic [7:0]    w_crc_chk_nxt;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
    logic fb;
    fb = crc[7] ^ b;
    return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  assign w_shift     = (r_state == S_LOAD) && (r_occ != 4'd0);
  assign w_last_bit  = (r_bit_cnt == C_LAST);
  // Bits of the total not yet taken into the buffer.
  assign w_unacc     = C_TOTAL - r_bit_cnt - CW'(r_occ);
  // Bits still to be shifted after this cycle's shift; bounds the next byte.
  assign w_rem_after = C_TOTAL - r_bit_cnt - CW'(w_shift);
  // Ready when the buffer is empty or drains this cycle, so a continuously
  // offered byte lands without a bubble.
  assign w_ready     = (r_state == S_LOAD) && (r_occ <= 4'd1) && (w_unacc != '0);
  assign w_accept    = w_ready && data_valid;
  assign w_occ_new   = (w_rem_after >= CW'(8)) ? 4'd8 : 4'(w_rem_after);
  assign w_crc_chk_nxt = crc8_step(r_crc_chk, chain_tail);

  assign error = r_error;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    setup       = 1'b0;
    param_in    = 1'b0;
    data_ready  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        busy       = 1'b1;
        data_ready = w_ready;
        // An empty buffer (host stall) leaves setup low so the chain holds.
        if (w_shift) begin
          setup    = 1'b1;
          param_in = r_buf[0];
          if (w_last_bit) w_state_nxt = VERIFY_EN ? S_VERIFY : S_FINISH;
        end
      end
      S_VERIFY: begin
        busy     = 1'b1;
        setup    = 1'b1;
        // Feed the tail straight back so the chain ends where it started.
        param_in = chain_tail;
        if (w_last_bit) w_state_nxt = S_FINISH;
      end
      S_FINISH: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_occ     <= 4'd0;
      r_bit_cnt <= '0;
      r_crc     <= 8'h00;
      r_crc_chk <= 8'h00;
      r_error   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_occ     <= 4'd0;
            r_bit_cnt <= '0;
            r_crc     <= 8'h00;
            r_crc_chk <= 8'h00;
            r_error   <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_accept)     r_occ <= w_occ_new;
          else if (w_shift) r_occ <= r_occ - 4'd1;
          if (w_shift) begin
            r_crc     <= crc8_step(r_crc, r_buf[0]);
            // Counter is reused by VERIFY, so it restarts at the last bit.
            r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + CW'(1);
          end
        end
        S_VERIFY: begin
          r_crc_chk <= w_crc_chk_nxt;
          r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + CW'(1);
          if (w_last_bit) r_error <= (w_crc_chk_nxt != r_crc);
        end
        default: ;
      endcase
    end
  end

  // Byte shift buffer: pure data, validity is tracked by r_occ.
  always_ff @(posedge clk) begin
    if (w_accept)     r_buf <= data_in;
    else if (w_shift) r_buf <= {1'b0, r_buf[7:1]};
  end

endmodule

// File: tb/tb_bnn_param_loader.sv
// -----------------------------------------------------------------------------
// tb_bnn_param_loader
//   Directed bench for bnn_param_loader. dut0 runs with the verify pass,
//   dut1 with VERIFY_EN=0; both share the host stream. Each has a behavioural
//   88-bit FIFO chain model (tail = bit 0).
// -----------------------------------------------------------------------------
module tb_bnn_param_loader;

  localparam int TB = 88;
  localparam logic [TB-1:0] FLIP = TB'(1) << 10;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       data_valid = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic ready0, setup0, pin0, busy0, done0, err0, tail0;
  logic ready1, setup1, pin1, busy1, done1, err1, tail1;

  logic [TB-1:0] chain0 = '0;
  logic [TB-1:0] chain1 = '0;

  assign tail0 = chain0[0];
  assign tail1 = chain1[0];

  always #5 clk = ~clk;

  bnn_param_loader #(.VERIFY_EN(1'b1)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .data_in(data_in),
    .data_valid(data_valid), .data_ready(ready0), .chain_tail(tail0),
    .setup(setup0), .param_in(pin0), .busy(busy0), .done(done0), .error(err0)
  );

  bnn_param_loader #(.VERIFY_EN(1'b0)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .data_in(data_in),
    .data_valid(data_valid), .data_ready(ready1), .chain_tail(tail1),
    .setup(setup1), .param_in(pin1), .busy(busy1), .done(done1), .error(err1)
  );

  int  n_chk = 0;
  int  n_err = 0;
  bit  arm = 0, trk = 0, aborting = 0, corrupt_en = 0;
  int  t = 0, sc0 = 0, sc1 = 0, rises0 = 0, bad_setup = 0;
  int  done_t0 = -1, done_t1 = -1;
  bit  prev0 = 0;
  logic [7:0] pb [11];

  // Chain models: shift toward the tail while setup is high.
  always @(posedge clk) begin
    if (setup0)
      chain0 <= {pin0, chain0[TB-1:1]} ^ ((corrupt_en && sc0 == TB + 40) ? FLIP : '0);
    if (setup1)
      chain1 <= {pin1, chain1[TB-1:1]};
  end

  // Cycle 0 is the cycle in which start is high.
  always @(negedge clk) begin
    if (arm && start) begin
      arm = 0; trk = 1; t = 0;
      sc0 = 0; sc1 = 0; rises0 = 0; bad_setup = 0; prev0 = 0;
      done_t0 = -1; done_t1 = -1;
    end else if (trk) begin
      t++;
    end
    if (trk) begin
      if (setup0) begin
        sc0++;
        if (!prev0) rises0++;
      end
      prev0 = setup0;
      if (setup1) sc1++;
      if ((setup0 && !busy0) || (setup1 && !busy1)) bad_setup++;
      if (done0) done_t0 = t;
      if (done1) done_t1 = t;
    end
  end

  task automatic chk(input string tag, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [TB-1:0] exp_chain();
    logic [TB-1:0] e;
    e = '0;
    for (int j = 0; j < 11; j++)
      for (int i = 0; i < 8; i++)
        e[8*j + i] = pb[j][i];
    return e;
  endfunction

  task automatic do_start();
    @(posedge clk); #1;
    arm = 1; start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    n = 0;
    while (!ready0 && !aborting && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (aborting) return;
    if (!ready0) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    if (gap) repeat (3) begin @(posedge clk); #1; end
    if (aborting) return;
    data_in = b; data_valid = 1;
    @(posedge clk); #1;
    data_valid = 0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_t0 < 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (done_t0 < 0) chk("done_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_load(input bit gap, input bit midstart, input bit rst_mid);
    do_start();
    chk("busy_after_start", busy0, 1);
    chk("err_clr_on_start", err0, 0);
    fork
      begin
        for (int i = 0; i < 11; i++) send_byte(pb[i], gap && (i > 0));
      end
      begin
        if (midstart) begin
          int n;
          n = 0;
          while (sc0 < 30 && n < 300) begin @(posedge clk); #1; n++; end
          start = 1;
          @(posedge clk); #1;
          start = 0;
        end
      end
      begin
        if (rst_mid) begin
          int n;
          n = 0;
          while (sc0 < 50 && n < 300) begin @(posedge clk); #1; n++; end
          aborting = 1;
          #2 reset_n = 0;
          #1;
          chk("rst_setup", setup0, 0);
          chk("rst_busy", busy0, 0);
          chk("rst_ready", ready0, 0);
          repeat (2) @(posedge clk);
          #1 reset_n = 1;
        end
      end
    join
    data_valid = 0;
    aborting = 0;
    if (!rst_mid) wait_done();
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_setup", setup0, 0);
    chk("reset_param_in", pin0, 0);
    chk("reset_ready", ready0, 0);
    chk("reset_busy", busy0, 0);
    chk("reset_done", done0, 0);
    chk("reset_error", err0, 0);
    reset_n = 1;
    @(posedge clk); #1;
    chk("idle_ready_ignores_valid", ready0, 0);

    // Streamed load 0x01..0x0B
    for (int i = 0; i < 11; i++) pb[i] = 8'(i + 1);
    run_load(0, 0, 0);
    chk("s_setup_cycles", sc0, 176);
    chk("s_setup_bursts", rises0, 1);
    chk("s_done_time", done_t0, 178);
    chk("s_chain", chain0, exp_chain());
    chk("s_error", err0, 0);
    chk("s_busy_idle", busy0, 0);
    chk("s_setup_idle", bad_setup, 0);
    chk("s_ne_setup_cycles", sc1, 88);
    chk("s_ne_done_time", done_t1, 90);
    chk("s_ne_chain", chain1, exp_chain());

    // Host stalls after every byte
    run_load(1, 0, 0);
    chk("g_setup_cycles", sc0, 176);
    chk("g_setup_bursts", rises0, 11);
    chk("g_done_time", done_t0, 208);
    chk("g_chain", chain0, exp_chain());
    chk("g_error", err0, 0);

    // Corruption during VERIFY cycle 40
    pb[0] = 8'h3C; pb[5] = 8'hC3;
    corrupt_en = 1;
    run_load(0, 0, 0);
    corrupt_en = 0;
    chk("c_error", err0, 1);
    repeat (5) @(negedge clk);
    chk("c_error_sticky", err0, 1);
    chk("c_ne_error", err1, 0);

    // All ones; start clears the sticky error
    for (int i = 0; i < 11; i++) pb[i] = 8'hFF;
    run_load(0, 0, 0);
    chk("f_ne_setup_cycles", sc1, 88);
    chk("f_ne_done_time", done_t1, 90);
    chk("f_ne_chain", chain1, {TB{1'b1}});
    chk("f_chain", chain0, {TB{1'b1}});
    chk("f_error", err0, 0);

    // Start pulsed mid-LOAD is ignored
    for (int i = 0; i < 11; i++) pb[i] = 8'(8'h10 * i + 8'h05);
    run_load(0, 1, 0);
    chk("m_setup_cycles", sc0, 176);
    chk("m_done_time", done_t0, 178);
    chk("m_chain", chain0, exp_chain());
    chk("m_error", err0, 0);

    // Reset mid-LOAD, then a clean load
    for (int i = 0; i < 11; i++) pb[i] = 8'(i + 1);
    run_load(0, 0, 1);
    for (int i = 0; i < 11; i++) pb[i] = 8'hA5 ^ 8'(i * 7);
    run_load(0, 0, 0);
    chk("r_setup_cycles", sc0, 176);
    chk("r_done_time", done_t0, 178);
    chk("r_chain", chain0, exp_chain());
    chk("r_error", err0, 0);
    chk("r_ne_chain", chain1, exp_chain());

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bnn_param_loader.md
Name: bnn_param_loader

Overview:
- Sequences weight/bias loading into the serial parameter chain of the tiny_bnn neuron array.
- Accepts parameter bytes from a host over a valid/ready stream and shifts them LSB-first into the chain, one bit per cycle.
- After the load, rotates the whole chain once through itself and checks a CRC-8 to confirm the load.
- Drives the array's setup and param_in; observes the chain tail (param_out).

Parameters:
- N_NEURONS, 8, number of neurons in the chain.
- BITS_PER_NEURON, 11, parameter bits per neuron (8 weights + 3 bias).
- TOTAL_BITS, N_NEURONS*BITS_PER_NEURON (88), derived; chain length in bits.
- VERIFY_EN, 1, 1 = run the rotate/CRC verify pass; 0 = skip it.

Ports:
- clk  in  1  system clock, rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load when idle.
- data_in  in  8  parameter byte; bit 0 is shifted first.
- data_valid  in  1  data_in valid.
- data_ready  out  1  loader accepts data_in this cycle.
- chain_tail  in  1  serial output of the last neuron in the chain.
- setup  out  1  chain shift enable / array setup mode.
- param_in  out  1  serial bit into the first neuron.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at end of sequence.
- error  out  1  verify mismatch; sticky until next accepted start.

Behaviour:
- Reset (async, reset_n=0):
  - State IDLE.
  - setup=0, param_in=0, data_ready=0, busy=0, done=0, error=0.
  - Counters and CRC cleared.
  - Reset mid-load or mid-verify abandons the sequence. Chain contents are undefined afterwards.
- States: IDLE -> LOAD -> (VERIFY if VERIFY_EN) -> FINISH -> IDLE.
- IDLE:
  - start=1 -> LOAD next cycle; clears error, bit_cnt, crc.
  - start in any other state is ignored.
- LOAD:
  - 8-bit shift buffer with a 0..8 occupancy count.
  - data_ready=1 iff the buffer is empty, or will empty this cycle (occupancy 1 and shifting).
  - A byte is accepted on data_valid & data_ready; occupancy becomes min(8, TOTAL_BITS-bit_cnt).
  - Excess high bits of the final partial byte are discarded (88 bits = 11 full bytes, so none by default).
  - When occupancy>0: setup=1 and param_in=buf[0] in that cycle; buf shifts right; bit_cnt++; crc updated with the bit.
  - When occupancy==0 (host stall): setup=0, param_in=0. The chain holds, so stalls never corrupt the chain.
  - Every cycle with setup=1 in LOAD shifts exactly one valid bit; the total count of such cycles is TOTAL_BITS.
  - Zero-bubble throughput: a byte offered continuously is accepted in the same cycle the last bit of the previous byte shifts.
  - When bit_cnt reaches TOTAL_BITS: data_ready=0; go to VERIFY (or FINISH if VERIFY_EN=0). crc_ref <= crc.
- VERIFY:
  - setup=1 for exactly TOTAL_BITS consecutive cycles.
  - param_in=chain_tail (combinational), so the chain rotates fully back to its loaded state.
  - crc_chk is updated with chain_tail each cycle.
  - Chain tail order equals load order because the chain is FIFO, so crc_chk == crc_ref when intact.
  - After TOTAL_BITS cycles: error <= (crc_chk != crc_ref); go to FINISH.
- FINISH:
  - setup=0; done=1 for one cycle; busy=0 the same cycle; then IDLE.
  - error holds its value until the next accepted start.
- CRC: CRC-8, polynomial x^8+x^2+x+1 (0x07), init 0x00, bit-serial, MSB feedback: fb=crc[7]^bit; crc={crc[6:0],0}^(fb?0x07:0).
- Counters are sized for TOTAL_BITS (clog2(TOTAL_BITS+1)) and must not wrap.
- data_valid while not in LOAD is ignored (data_ready=0).
- setup is never high in IDLE or FINISH.

Test Plan:
- Streamed load, 11 bytes 0x01..0x0B with data_valid held -> setup high exactly 88 consecutive LOAD cycles, then 88 VERIFY cycles. done pulses at cycle 1+88+88+1 after start. Chain model holds bytes in order. error=0.
- Host stalls: 3-cycle gap inserted after every byte -> setup=0 during each gap. Final chain contents identical to the streamed case; error=0.
- Corruption: bench flips one chain-model bit during VERIFY cycle 40 -> error=1 after done. error stays 1 until the next start, which clears it.
- VERIFY_EN=0, bytes all 0xFF -> setup high 88 cycles only; done at cycle 90; all chain bits 1.
- start pulsed again mid-LOAD at bit 30 -> ignored; bit_cnt and chain unaffected.
- reset_n asserted at bit 50 of LOAD -> setup, busy, data_ready all 0 immediately (async). Next start performs a complete, correct load with error=0.
